// File: rtl/quad_sqrt.sv
// quad_sqrt: integer square root stage that follows the sum-of-squares block.
// Each accepted radicand c_in is processed with a digit-by-digit restoring
// square root, two radicand bits per cycle. The block returns
// root = floor(sqrt(c_in)) and rem = c_in - root^2.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   c_in holds a valid radicand
//   in_ready   block can accept an operand (registered)
//   c_in       IN_W-bit unsigned radicand
//   out_valid  root/rem hold a valid result (held until out_ready)
//   out_ready  consumer accepts the result
//   root       OUT_W-bit floor(sqrt(c_in))
//   rem        OUT_W+1-bit remainder, always in 0..2*root
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// CALC  | OUT_W iterations, one root bit per edge
// DONE  | result presented, held until out_ready
module quad_sqrt #(
  parameter int IN_W  = 29,
  parameter int OUT_W = (IN_W + 1) / 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] root,
  output logic [OUT_W:0]   rem
);

  localparam int EXT_W = 2 * OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [EXT_W-1:0]   rad_q;
  logic [OUT_W-1:0]   proot_q;
  logic [OUT_W+1:0]   prem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   root_q;
  logic [OUT_W:0]     rem_q;

  logic [OUT_W+1:0]   shifted_d;
  logic [OUT_W+1:0]   sub_d;
  logic [OUT_W+1:0]   trial_d;
  logic               ge_d;
  logic [OUT_W+1:0]   prem_d;
  logic [OUT_W-1:0]   proot_d;

  // The trial difference always fits in OUT_W+2 bits as a two's-complement
  // value, so its MSB is a valid sign bit for the restore decision.
  assign shifted_d = (prem_q << 2) | {{OUT_W{1'b0}}, rad_q[EXT_W-1 -: 2]};
  assign sub_d     = {proot_q, 2'b01};
  assign trial_d   = shifted_d - sub_d;
  assign ge_d      = ~trial_d[OUT_W+1];
  assign prem_d    = ge_d ? trial_d : shifted_d;
  assign proot_d   = (proot_q << 1) | OUT_W'(ge_d);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      proot_q     <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      root_q      <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid) begin
            rad_q      <= EXT_W'(c_in);
            proot_q    <= '0;
            prem_q     <= '0;
            cnt_q      <= CNT_W'(OUT_W - 1);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          rad_q   <= rad_q << 2;
          proot_q <= proot_d;
          prem_q  <= prem_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            // final remainder is bounded by 2*root, so OUT_W+1 bits suffice
            root_q      <= proot_d;
            rem_q       <= prem_d[OUT_W:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign root      = root_q;
  assign rem       = rem_q;

endmodule

// File: tb/tb_quad_sqrt.sv
// Testbench for quad_sqrt: directed vectors with hand-computed results,
// handshake/backpressure/reset checks, then a random quad-like stream.
// Expected results go into a queue at acceptance; a monitor pops and
// compares on every output handshake.
module tb_quad_sqrt;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] c_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] root;
  logic [15:0] rem;

  typedef struct {
    longint c;
    longint r;
    longint m;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_pop = 0;
  bit   rand_bp = 1'b0;

  quad_sqrt #(.IN_W(29)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // floor(sqrt(c)) by binary search
  function automatic longint isqrt(input longint c);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= c) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic send(input longint c, input longint r, input longint m);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    c_in     = 29'(c);
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.c = c; e.r = r; e.m = m;
    sb.push_back(e);
    n_push++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: root=%0d rem=%0d, expected no result", root, rem);
        end else begin
          e = sb.pop_front();
          n_pop++;
          chk($sformatf("root(c=%0d)", e.c), root, e.r);
          chk($sformatf("rem(c=%0d)", e.c), rem, e.m);
        end
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n;
    longint a, b, c, r;

    // reset values
    #23;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_root", root, 0);
    chk("rst_rem", rem, 0);
    @(negedge clk) rstn = 1'b1;
    #1 chk("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("rel_in_ready_after_edge", in_ready, 1);

    // c_in = 0 and latency
    out_ready = 1'b1;
    send(0, 0, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 15);
    drain();

    send(15, 3, 6);
    send(1, 1, 0);
    send(16, 4, 0);
    send(536870911, 23170, 22011);
    send(134217728, 11585, 5503);
    drain();

    // backpressure, with in_valid noise during CALC and DONE
    out_ready = 1'b0;
    send(12345, 111, 24);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      c_in     = 29'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      c_in     = 29'($urandom);
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_root", root, 111);
      chk("bp_rem", rem, 24);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid_fall", out_valid, 0);
    chk("hs_in_ready_rise", in_ready, 1);
    chk("hs_root_held", root, 111);
    chk("hs_rem_held", rem, 24);
    chk("hs_result_popped", sb.size(), 0);

    // reset during CALC
    send(1000, 31, 39);
    repeat (6) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_root", root, 0);
    chk("abort_rem", rem, 0);
    n_push -= sb.size();
    sb.delete();
    @(negedge clk) rstn = 1'b1;
    #1 chk("abort_in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("abort_in_ready_after_edge", in_ready, 1);
    send(1000, 31, 39);
    drain();

    // random quad-like stream
    rand_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a = longint'($urandom_range(0, 16383)) - 8192;
      b = longint'($urandom_range(0, 16383)) - 8192;
      c = a * a + b * b;
      r = isqrt(c);
      send(c, r, c - r * r);
    end
    drain();
    rand_bp = 1'b0;
    chk("stream_count", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
